// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage F/D/E/M/W pipeline.
// It tracks in-flight E/M/W destination and control state and derives stall, flush and forwarding controls.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSrcD,
  input  logic             BranchTakenE,
  input  logic             MemBusyM,
  input  logic             cnt_clr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [REG_W-1:0] PC_IDX = {REG_W{1'b1}};

  logic [REG_W-1:0] ra1_e, ra2_e, wa3_e;
  logic             reg_write_e, mem_to_reg_e, pc_src_e;
  logic [REG_W-1:0] wa3_m;
  logic             reg_write_m, pc_src_m;
  logic [REG_W-1:0] wa3_w;
  logic             reg_write_w, pc_src_w;

  logic ldr_stall;
  logic pc_wr_pend;

  assign ldr_stall  = mem_to_reg_e & reg_write_e & ((wa3_e == RA1D) | (wa3_e == RA2D));
  assign pc_wr_pend = PCSrcD | pc_src_e | pc_src_m;

  // A busy data memory freezes everything up to M and bubbles W; hazard terms
  // stay encoded in the frozen shadows and reappear once memory is ready.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (MemBusyM) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = ldr_stall | pc_wr_pend;
      StallD = ldr_stall;
      FlushD = pc_wr_pend | pc_src_w | BranchTakenE;
      FlushE = ldr_stall | BranchTakenE;
    end
  end

  // R15 reads come from the PC path, so they are never forwarded; M wins over W.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (ra1_e != PC_IDX) begin
      if (reg_write_m && (wa3_m == ra1_e))      ForwardAE = 2'b10;
      else if (reg_write_w && (wa3_w == ra1_e)) ForwardAE = 2'b01;
    end
    if (ra2_e != PC_IDX) begin
      if (reg_write_m && (wa3_m == ra2_e))      ForwardBE = 2'b10;
      else if (reg_write_w && (wa3_w == ra2_e)) ForwardBE = 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra1_e        <= '0;
      ra2_e        <= '0;
      wa3_e        <= '0;
      reg_write_e  <= 1'b0;
      mem_to_reg_e <= 1'b0;
      pc_src_e     <= 1'b0;
      wa3_m        <= '0;
      reg_write_m  <= 1'b0;
      pc_src_m     <= 1'b0;
      wa3_w        <= '0;
      reg_write_w  <= 1'b0;
      pc_src_w     <= 1'b0;
    end else begin
      if (!StallE) begin
        ra1_e        <= RA1D;
        ra2_e        <= RA2D;
        wa3_e        <= WA3D;
        reg_write_e  <= RegWriteD & ~FlushE;
        mem_to_reg_e <= MemtoRegD & ~FlushE;
        pc_src_e     <= PCSrcD & ~FlushE;
      end
      if (!StallM) begin
        wa3_m       <= wa3_e;
        reg_write_m <= reg_write_e;
        pc_src_m    <= pc_src_e;
      end
      wa3_w       <= wa3_m;
      reg_write_w <= reg_write_m & ~FlushW;
      pc_src_w    <= pc_src_m & ~FlushW;
    end
  end

  // Debug counters saturate rather than wrap so long stalls stay visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((FlushD || FlushE) && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
